// File: rtl/clk_div_monitor_if.sv
// Bundle between a divided-clock source and its receive-side monitor.
// The master drives the clock under test and enable; the slave reports measurements.
interface clk_div_monitor_if #(
   parameter int CNT_W = 8
);
   logic             clk_in;
   logic             en;
   logic [CNT_W-1:0] period;
   logic [CNT_W-1:0] high_time;
   logic             meas_valid;
   logic             locked;
   logic             err;
   logic             stuck;

   modport master (
      output clk_in, en,
      input  period, high_time, meas_valid, locked, err, stuck
   );

   modport slave (
      input  clk_in, en,
      output period, high_time, meas_valid, locked, err, stuck
   );
endinterface

// File: rtl/clk_div_monitor.sv
// Measures a divided clock (period and high time) in reference-clock cycles,
// declares lock after consecutive in-spec periods, and flags mismatches and stalls.
module clk_div_monitor #(
   parameter int CNT_W       = 8,
   parameter int EXP_DIV     = 15,
   parameter int TOL         = 0,
   parameter int LOCK_CNT    = 4,
   parameter int TIMEOUT     = 64,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   clk_div_monitor_if.slave mon
);

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      ACQ      = 2'd1,
      LOCKED   = 2'd2
   } state_e;

   localparam int               MCNT_W    = $clog2(LOCK_CNT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX   = '1;
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
   localparam logic [CNT_W-1:0] EXP_C     = CNT_W'(EXP_DIV);
   localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOL);
   localparam logic [CNT_W-1:0] HALF_LO   = CNT_W'(EXP_DIV / 2);
   localparam logic [CNT_W-1:0] HALF_HI   = CNT_W'((EXP_DIV + 1) / 2);
   localparam logic [MCNT_W-1:0] LOCK_C   = MCNT_W'(LOCK_CNT);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   s_dly_q, s_dly_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [CNT_W-1:0]       hcnt_q, hcnt_d;
   logic [MCNT_W-1:0]      mcnt_q, mcnt_d;
   logic                   first_q, first_d;
   state_e                 state_q, state_d;
   logic [CNT_W-1:0]       period_q, period_d;
   logic [CNT_W-1:0]       high_time_q, high_time_d;
   logic                   meas_valid_q, meas_valid_d;
   logic                   locked_q, locked_d;
   logic                   err_q, err_d;
   logic                   stuck_q, stuck_d;

   logic             s;
   logic             rise;
   logic             arm;
   logic             valid;
   logic             timeout;
   logic [CNT_W-1:0] period_diff;
   logic             match;

   // SYNC_STAGES must be at least 2 for the shift below to be well formed
   assign sync_d  = {sync_q[SYNC_STAGES-2:0], mon.clk_in};
   assign s       = sync_q[SYNC_STAGES-1];
   assign s_dly_d = s;
   assign rise    = s & ~s_dly_q;

   assign arm         = mon.en & rise & first_q;
   assign valid       = mon.en & rise & ~first_q;
   assign timeout     = mon.en & ~rise & (cnt_q == TIMEOUT_C);
   assign period_diff = (cnt_q >= EXP_C) ? (cnt_q - EXP_C) : (EXP_C - cnt_q);
   assign match       = (period_diff <= TOL_C) && ((hcnt_q == HALF_LO) || (hcnt_q == HALF_HI));

   always_comb begin
      cnt_d  = cnt_q;
      hcnt_d = hcnt_q;
      if (!mon.en) begin
         cnt_d  = '0;
         hcnt_d = '0;
      end else if (rise) begin
         cnt_d  = CNT_ONE;
         hcnt_d = CNT_ONE;
      end else begin
         if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
         if (s && (hcnt_q != CNT_MAX)) hcnt_d = hcnt_q + CNT_ONE;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= UNLOCKED;
         mcnt_q  <= '0;
         first_q <= 1'b1;
      end else begin
         state_q <= state_d;
         mcnt_q  <= mcnt_d;
         first_q <= first_d;
      end
   end

   // A disable or a stall sends the FSM back to UNLOCKED and re-arms the first flag
   always_comb begin
      state_d = state_q;
      mcnt_d  = mcnt_q;
      first_d = first_q;
      if (!mon.en || timeout) begin
         state_d = UNLOCKED;
         mcnt_d  = '0;
         first_d = 1'b1;
      end else if (arm) begin
         state_d = ACQ;
         mcnt_d  = '0;
         first_d = 1'b0;
      end else if (valid) begin
         case (state_q)
            ACQ: begin
               if (match) begin
                  mcnt_d = mcnt_q + 1'b1;
                  if (mcnt_d == LOCK_C) state_d = LOCKED;
               end else begin
                  mcnt_d = '0;
               end
            end
            LOCKED: begin
               if (!match) begin
                  state_d = ACQ;
                  mcnt_d  = '0;
               end
            end
            default: state_d = state_q;
         endcase
      end
   end

   always_comb begin
      meas_valid_d = valid;
      err_d        = valid & ~match & (state_q == LOCKED);
      locked_d     = (state_d == LOCKED);
      period_d     = valid ? cnt_q  : period_q;
      high_time_d  = valid ? hcnt_q : high_time_q;
      stuck_d      = stuck_q;
      if (!mon.en || rise) stuck_d = 1'b0;
      else if (timeout)    stuck_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q       <= '0;
         s_dly_q      <= 1'b0;
         cnt_q        <= '0;
         hcnt_q       <= '0;
         period_q     <= '0;
         high_time_q  <= '0;
         meas_valid_q <= 1'b0;
         locked_q     <= 1'b0;
         err_q        <= 1'b0;
         stuck_q      <= 1'b0;
      end else begin
         sync_q       <= sync_d;
         s_dly_q      <= s_dly_d;
         cnt_q        <= cnt_d;
         hcnt_q       <= hcnt_d;
         period_q     <= period_d;
         high_time_q  <= high_time_d;
         meas_valid_q <= meas_valid_d;
         locked_q     <= locked_d;
         err_q        <= err_d;
         stuck_q      <= stuck_d;
      end
   end

   assign mon.period     = period_q;
   assign mon.high_time  = high_time_q;
   assign mon.meas_valid = meas_valid_q;
   assign mon.locked     = locked_q;
   assign mon.err        = err_q;
   assign mon.stuck      = stuck_q;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed bench for clk_div_monitor: drives /15, /14 and disturbed clocks
// and checks measurements, lock, err, stuck, reset and enable behaviour.
module tb_clk_div_monitor;

   localparam int CNT_W = 8;

   logic clk = 1'b0;
   logic rst;

   int nCompared   = 0;
   int nMismatched = 0;
   int cyc         = 0;
   int errCount    = 0;
   int lastMvCyc   = 0;

   bit drvOn   = 1'b0;
   int drvHigh = 8;
   int drvLow  = 7;

   clk_div_monitor_if #(.CNT_W(CNT_W)) bus ();

   clk_div_monitor #(
      .CNT_W(CNT_W), .EXP_DIV(15), .TOL(0), .LOCK_CNT(4), .TIMEOUT(64), .SYNC_STAGES(2)
   ) dut (
      .clk (clk),
      .rst (rst),
      .mon (bus.slave)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial forever begin
      @(posedge clk);
      #2;
      if (bus.err) errCount++;
   end

   // Divided clock source; high/low lengths are latched at the start of each period
   initial begin : divDriver
      int phase;
      int curHigh;
      int curLow;
      phase      = 0;
      curHigh    = 8;
      curLow     = 7;
      bus.clk_in = 1'b0;
      forever begin
         @(negedge clk);
         if (!drvOn) begin
            bus.clk_in = 1'b0;
            phase      = 0;
         end else begin
            if (phase == 0) begin
               curHigh = drvHigh;
               curLow  = drvLow;
            end
            bus.clk_in = (phase < curHigh);
            phase      = (phase + 1 == curHigh + curLow) ? 0 : phase + 1;
         end
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nCompared++;
      if (got !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic applyStimulus(input bit newEn, input bit newDrv, input int high, input int low);
      bus.en  = newEn;
      drvOn   = newDrv;
      drvHigh = high;
      drvLow  = low;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic waitMv(input string tag, input int expPeriod, input int expHigh, input int expGap);
      bit seen = 1'b0;
      for (int k = 0; k < 100 && !seen; k++) begin
         tick();
         seen = bus.meas_valid;
      end
      checkOutput({tag, "_mv"}, 32'(seen), 1);
      if (seen) begin
         checkOutput({tag, "_period"}, 32'(bus.period), expPeriod);
         checkOutput({tag, "_high"}, 32'(bus.high_time), expHigh);
         if (expGap != 0) checkOutput({tag, "_gap"}, cyc - lastMvCyc, expGap);
         lastMvCyc = cyc;
      end
   endtask

   // Four good /15 measurements after an arming rise; lock appears on the fourth
   task automatic runLock(input string tag, input int firstGap);
      for (int i = 0; i < 4; i++) begin
         waitMv(tag, 15, 8, (i == 0) ? firstGap : 15);
         checkOutput({tag, "_locked"}, 32'(bus.locked), (i == 3) ? 1 : 0);
         checkOutput({tag, "_err"}, 32'(bus.err), 0);
      end
   endtask

   initial begin : mainSeq
      int  errBefore;
      int  enCyc;
      bit  seen;
      bit  prevLocked;
      int  mvInWindow;

      rst = 1'b0;
      applyStimulus(0, 0, 8, 7);
      repeat (3) tick();
      checkOutput("reset_outputs",
                  {12'd0, bus.period, bus.high_time, bus.meas_valid, bus.locked, bus.err, bus.stuck}, 0);
      @(negedge clk);
      rst = 1'b1;

      // Ideal /15: arm, then lock on the fourth measurement
      errBefore = errCount;
      applyStimulus(1, 1, 8, 7);
      runLock("t1", 0);

      // One 16-cycle period while locked
      drvLow = 8;
      waitMv("t3_pre", 15, 8, 15);
      checkOutput("t3_pre_locked", 32'(bus.locked), 1);
      drvLow = 7;
      waitMv("t3_bad", 16, 8, 16);
      checkOutput("t3_err", 32'(bus.err), 1);
      checkOutput("t3_unlocked", 32'(bus.locked), 0);
      tick();
      checkOutput("t3_err_pulse", 32'(bus.err), 0);
      runLock("t3_relock", 15);
      checkOutput("t3_err_count", errCount - errBefore, 1);

      // Stall after lock
      drvOn      = 1'b0;
      seen       = 1'b0;
      prevLocked = bus.locked;
      for (int k = 0; k < 100 && !seen; k++) begin
         tick();
         if (bus.stuck) seen = 1'b1;
         else prevLocked = bus.locked;
      end
      checkOutput("t4_stuck_seen", 32'(seen), 1);
      if (seen) begin
         checkOutput("t4_stuck_delay", cyc - lastMvCyc, 64);
         checkOutput("t4_locked_drop", 32'(bus.locked), 0);
         checkOutput("t4_locked_before", 32'(prevLocked), 1);
      end
      applyStimulus(1, 1, 8, 7);
      seen = 1'b0;
      for (int k = 0; k < 20 && !seen; k++) begin
         tick();
         if (!bus.stuck) seen = 1'b1;
      end
      checkOutput("t4_stuck_clear", 32'(seen), 1);
      checkOutput("t4_clear_no_mv", 32'(bus.meas_valid), 0);
      lastMvCyc = cyc;
      runLock("t4_relock", 15);

      // Asynchronous reset between clock edges while locked
      #3;
      rst   = 1'b0;
      drvOn = 1'b0;
      #1;
      checkOutput("t5_async_reset",
                  {12'd0, bus.period, bus.high_time, bus.meas_valid, bus.locked, bus.err, bus.stuck}, 0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      repeat (3) tick();
      applyStimulus(1, 1, 8, 7);
      runLock("t5", 0);

      // Enable dropped for 20 cycles while locked
      applyStimulus(0, 1, 8, 7);
      mvInWindow = 0;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (bus.meas_valid) mvInWindow++;
      end
      checkOutput("t6_no_mv", mvInWindow, 0);
      checkOutput("t6_locked", 32'(bus.locked), 0);
      checkOutput("t6_period_hold", 32'(bus.period), 15);
      checkOutput("t6_stuck", 32'(bus.stuck), 0);
      applyStimulus(1, 1, 8, 7);
      enCyc = cyc;
      waitMv("t6_first", 15, 8, 0);
      checkOutput("t6_arm_only", 32'((cyc - enCyc) >= 16), 1);
      for (int i = 0; i < 3; i++) begin
         waitMv("t6_relock", 15, 8, 15);
         checkOutput("t6_relock_locked", 32'(bus.locked), (i == 2) ? 1 : 0);
      end

      // /14 clock from a fresh start never locks and never errs
      applyStimulus(0, 0, 7, 7);
      repeat (5) tick();
      errBefore = errCount;
      applyStimulus(1, 1, 7, 7);
      for (int i = 0; i < 6; i++) begin
         waitMv("t2", 14, 7, (i == 0) ? 0 : 14);
         checkOutput("t2_locked", 32'(bus.locked), 0);
      end
      repeat (3) tick();
      checkOutput("t2_no_err", errCount - errBefore, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
